mvb_fifo_rr_sched: RTL and testbench



---
 rtl/mvb_sched_pkg.sv | 39 +++
 rtl/rr_pick.sv | 37 +++
 rtl/mvb_fifo_rr_sched.sv | 140 ++++++++++++++
 tb/tb_mvb_fifo_rr_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvb_sched_pkg.sv
// Shared definitions for the MVB round-robin FIFO write scheduler.
//   sched_state_t : scheduler FSM states (IDLE, LOCKED)
//   chan_w()      : width of a channel index, never less than 1 bit
//   rot_prio()    : rotate-priority search used by the round-robin picker
package mvb_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    // Upper bound on CHANNELS; sizes the rotate-priority search window.
    localparam int MAX_CHANNELS = 16;

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // dbl holds the request vector concatenated with itself, so reading n bits
    // upward from ptr is a rotation without any modulo arithmetic. Returns the
    // offset from ptr of the first set bit, or n when nothing is requested.
    function automatic logic [4:0] rot_prio(input logic [2*MAX_CHANNELS-1:0] dbl,
                                            input logic [4:0]                ptr,
                                            input int                        n);
        logic [4:0] off;
        logic       found;
        off   = 5'(n);
        found = 1'b0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            // ptr <= 15 and i <= 15, so the 5-bit index cannot wrap.
            if (!found && (i < n) && dbl[ptr + 5'(i)]) begin
                off   = 5'(i);
                found = 1'b1;
            end
        end
        return off;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   REQ : per-channel request vector
//   PTR : highest-priority channel for this pick
//   ANY : at least one request is present
//   IDX : first requesting channel at or above PTR, wrapping; don't-care when !ANY
module rr_pick
    import mvb_sched_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int CW       = chan_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] REQ,
    input  logic [CW-1:0]       PTR,
    output logic                ANY,
    output logic [CW-1:0]       IDX
);

    logic [2*MAX_CHANNELS-1:0] dbl;
    logic [4:0]                off;
    logic [5:0]                sum;

    // NOTE: every output of a combinational block gets a default at the top,
    // otherwise a missed branch holds its old value and infers a latch.
    always_comb begin
        dbl                  = '0;
        dbl[2*CHANNELS-1:0]  = {REQ, REQ};
        off                  = rot_prio(dbl, 5'(PTR), CHANNELS);
        ANY                  = |REQ;
        // PTR + off < 2*CHANNELS, so a single conditional subtract is the modulo.
        sum = 6'(PTR) + 6'(off);
        if (sum >= 6'(CHANNELS)) begin
            sum = sum - 6'(CHANNELS);
        end
        IDX = CW'(sum);
    end

endmodule

// File: rtl/mvb_fifo_rr_sched.sv
// Round-robin scheduler sharing one FIFO write port between CHANNELS MVB-style
// single-item requesters. A channel is granted for up to MAX_BURST items, then
// the pointer moves past it; every grant switch costs one IDLE cycle.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   ENABLE      : per-channel eligibility mask (quasi-static)
//   RX_DATA     : channel i item at [i*DATA_WIDTH +: DATA_WIDTH]
//   RX_SRC_RDY  : per-channel item valid
//   RX_DST_RDY  : per-channel accept (only the granted channel, only in LOCKED)
//   TX_DATA     : registered item for the FIFO write port
//   TX_CHAN     : source channel of TX_DATA
//   TX_SRC_RDY  : output valid (FIFO WR_EN)
//   TX_DST_RDY  : FIFO can accept (!WR_FULL)
//   BUSY        : high while a channel is granted
// An item held in the output register when RST_N asserts is dropped.
module mvb_fifo_rr_sched
    import mvb_sched_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int MAX_BURST  = 8,
    localparam int CW         = chan_w(CHANNELS)
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [CHANNELS-1:0]            ENABLE,
    input  logic [CHANNELS*DATA_WIDTH-1:0] RX_DATA,
    input  logic [CHANNELS-1:0]            RX_SRC_RDY,
    output logic [CHANNELS-1:0]            RX_DST_RDY,
    output logic [DATA_WIDTH-1:0]          TX_DATA,
    output logic [CW-1:0]                  TX_CHAN,
    output logic                           TX_SRC_RDY,
    input  logic                           TX_DST_RDY,
    output logic                           BUSY
);

    localparam logic [7:0]    LAST_CNT = 8'(MAX_BURST - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

    sched_state_t        state_q, state_d;
    logic [CW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [CW-1:0]       pick_idx;
    logic [CW-1:0]       grant_next;
    logic                pick_any;
    logic                out_free;
    logic                accept_g;
    logic                xfer;
    logic [CHANNELS-1:0] eligible;
    logic [DATA_WIDTH-1:0] rx_item [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign rx_item[i] = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign eligible   = ENABLE & RX_SRC_RDY;
    // The output register can take a new item if it is empty or being drained now.
    assign out_free   = !TX_SRC_RDY || TX_DST_RDY;
    assign grant_next = (grant_q == LAST_CH) ? '0 : grant_q + CW'(1);
    assign BUSY       = (state_q == LOCKED);

    rr_pick #(
        .CHANNELS(CHANNELS)
    ) u_pick (
        .REQ(eligible),
        .PTR(ptr_q),
        .ANY(pick_any),
        .IDX(pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        RX_DST_RDY = '0;
        accept_g   = 1'b0;
        xfer       = 1'b0;
        case (state_q)
            IDLE: begin
                // Arbitration cycle only: the grant is registered, nothing moves.
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                accept_g            = out_free && ENABLE[grant_q];
                RX_DST_RDY[grant_q] = accept_g;
                xfer                = accept_g && RX_SRC_RDY[grant_q];
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // A dropped request releases even while the output is stalled;
                // a disabled channel releases without transferring.
                if (!ENABLE[grant_q] || !RX_SRC_RDY[grant_q] ||
                    (xfer && (cnt_q == LAST_CNT))) begin
                    state_d = IDLE;
                    ptr_d   = grant_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the data register is reset too, because TX_DATA is an observable
    // output that must read zero after reset, not only a qualified datapath.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TX_DATA    <= '0;
            TX_CHAN    <= '0;
            TX_SRC_RDY <= 1'b0;
        end else if (xfer) begin
            // Load wins over unload, keeping one item per cycle in a burst.
            TX_DATA    <= rx_item[grant_q];
            TX_CHAN    <= grant_q;
            TX_SRC_RDY <= 1'b1;
        end else if (TX_DST_RDY) begin
            TX_SRC_RDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvb_fifo_rr_sched.sv
// Scoreboard bench for mvb_fifo_rr_sched: directed stimulus pushes the
// hand-ordered expected items into a queue; monitors pop and compare whenever
// an item is written into the (modelled) FIFO.
module tb_mvb_fifo_rr_sched;

    typedef struct packed {
        logic [1:0]  chan;
        logic [63:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;

    // Instance with MAX_BURST = 8
    logic [3:0]   en1;
    logic [255:0] rxd1;
    logic [3:0]   rxv1;
    logic [3:0]   rxr1;
    logic [63:0]  txd1;
    logic [1:0]   txc1;
    logic         txv1;
    logic         txr1;
    logic         busy1;

    // Instance with MAX_BURST = 1
    logic [3:0]   en2;
    logic [255:0] rxd2;
    logic [3:0]   rxv2;
    logic [3:0]   rxr2;
    logic [63:0]  txd2;
    logic [1:0]   txc2;
    logic         txv2;
    logic         txr2;
    logic         busy2;

    int           n_pass;
    int           n_total;
    exp_t         exp_q[$];
    int           exp2_q[$];
    exp_t         mon_e;
    int           mon2_c;

    logic [63:0]  src_mem [4][64];
    logic [5:0]   src_head [4];
    logic [5:0]   src_tail [4];

    mvb_fifo_rr_sched #(
        .CHANNELS(4), .DATA_WIDTH(64), .MAX_BURST(8)
    ) u_dut (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en1), .RX_DATA(rxd1),
        .RX_SRC_RDY(rxv1), .RX_DST_RDY(rxr1), .TX_DATA(txd1), .TX_CHAN(txc1),
        .TX_SRC_RDY(txv1), .TX_DST_RDY(txr1), .BUSY(busy1)
    );

    mvb_fifo_rr_sched #(
        .CHANNELS(4), .DATA_WIDTH(64), .MAX_BURST(1)
    ) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en2), .RX_DATA(rxd2),
        .RX_SRC_RDY(rxv2), .RX_DST_RDY(rxr2), .TX_DATA(txd2), .TX_CHAN(txc2),
        .TX_SRC_RDY(txv2), .TX_DST_RDY(txr2), .BUSY(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [63:0] mk(input int c, input int n);
        return {8'(c), 24'h5a5a5a, 32'(n)};
    endfunction

    task automatic drive();
        logic [63:0] cur [4];
        for (int c = 0; c < 4; c++) begin
            rxv1[2'(c)] = (src_head[2'(c)] != src_tail[2'(c)]);
            cur[2'(c)]  = rxv1[2'(c)] ? src_mem[2'(c)][src_head[2'(c)]] : 64'h0;
        end
        rxd1 = {cur[3], cur[2], cur[1], cur[0]};
    endtask

    task automatic load(input int c, input int n0, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            src_mem[2'(c)][src_tail[2'(c)]] = mk(c, n0 + i);
            src_tail[2'(c)] = src_tail[2'(c)] + 6'd1;
        end
    endtask

    task automatic expect_item(input int c, input int n);
        exp_t e;
        e.chan = 2'(c);
        e.data = mk(c, n);
        exp_q.push_back(e);
    endtask

    task automatic flush();
        for (int c = 0; c < 4; c++) begin
            src_head[2'(c)] = '0;
            src_tail[2'(c)] = '0;
        end
        drive();
    endtask

    function automatic logic src_empty();
        logic e;
        e = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (src_head[2'(c)] != src_tail[2'(c)]) e = 1'b0;
        end
        return e;
    endfunction

    // One clock: the handshake is sampled on the falling edge, the accepted
    // items are popped just after the rising edge, then the sources re-drive.
    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        acc = rxv1 & rxr1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (acc[2'(c)]) src_head[2'(c)] = src_head[2'(c)] + 6'd1;
        end
        drive();
    endtask

    // FIFO-side monitor for the MAX_BURST=8 instance.
    always @(negedge clk) begin
        if (rst_n && txv1 && txr1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_unexpected: got chan %0d data %0h, required no item", txc1, txd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_chan", 64'(txc1), 64'(mon_e.chan));
                check("tx_data", txd1, mon_e.data);
            end
        end
    end

    // FIFO-side monitor for the MAX_BURST=1 instance.
    always @(negedge clk) begin
        if (rst_n && txv2 && txr2) begin
            if (exp2_q.size() == 0) begin
                n_total++;
                $display("FAIL tx1_unexpected: got chan %0d, required no item", txc2);
            end else begin
                mon2_c = exp2_q.pop_front();
                check("tx1_chan", 64'(txc2), 64'(mon2_c));
                check("tx1_data", txd2, (mon2_c == 0) ? 64'hA0 : 64'hA3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic saw2;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        en1     = 4'b1111;
        txr1    = 1'b1;
        en2     = 4'b1111;
        rxv2    = 4'b0000;
        rxd2    = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        txr2    = 1'b1;
        flush();

        // Reset values
        #12;
        check("rst_tx_src_rdy", 64'(txv1), 64'h0);
        check("rst_tx_data", txd1, 64'h0);
        check("rst_tx_chan", 64'(txc1), 64'h0);
        check("rst_busy", 64'(busy1), 64'h0);
        check("rst_rx_dst_rdy", 64'(rxr1), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: all channels full, bursts of 8 with one bubble per switch
        for (int c = 0; c < 4; c++) begin
            load(c, 0, 8);
            for (int i = 0; i < 8; i++) expect_item(c, i);
        end
        drive();
        n = 0;
        while (!src_empty() && n < 200) begin
            tick();
            n++;
        end
        check("t1_cycles_for_32_items", 64'(n), 64'd36);
        repeat (3) tick();
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // Test 2: channel 2 alone, 3-item packet
        load(2, 50, 3);
        for (int i = 0; i < 3; i++) expect_item(2, 50 + i);
        drive();
        tick();
        check("t2_busy_after_grant", 64'(busy1), 64'h1);
        check("t2_rx_dst_rdy", 64'(rxr1), 64'h4);
        tick();
        check("t2_first_item_valid", 64'(txv1), 64'h1);
        check("t2_first_item_chan", 64'(txc1), 64'h2);
        tick();
        tick();
        tick();
        check("t2_busy_released", 64'(busy1), 64'h0);
        check("t2_ptr_after_release", 64'(u_dut.ptr_q), 64'h3);
        check("t2_tx_idle", 64'(txv1), 64'h0);

        // Test 3: FIFO full for 5 cycles mid-burst on channel 0
        load(0, 100, 6);
        for (int i = 0; i < 6; i++) expect_item(0, 100 + i);
        drive();
        repeat (3) tick();
        txr1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_data", txd1, mk(0, 101));
            check("t3_stall_chan", 64'(txc1), 64'h0);
            check("t3_stall_rx_dst_rdy", 64'(rxr1), 64'h0);
            check("t3_stall_count", 64'(u_dut.cnt_q), 64'h2);
        end
        txr1 = 1'b1;
        n = 0;
        while (!src_empty() && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Test 4: channel 2 masked, channel 1 disabled mid-burst
        en1  = 4'b1011;
        saw2 = 1'b0;
        load(1, 200, 8);
        load(0, 300, 2);
        load(2, 400, 2);
        load(3, 500, 2);
        for (int i = 0; i < 3; i++) expect_item(1, 200 + i);
        for (int i = 0; i < 2; i++) expect_item(3, 500 + i);
        for (int i = 0; i < 2; i++) expect_item(0, 300 + i);
        drive();
        for (int k = 0; k < 4; k++) begin
            tick();
            saw2 = saw2 | rxr1[2];
        end
        en1 = 4'b1001;
        #1;
        check("t4_disable_drops_accept", 64'(rxr1), 64'h0);
        tick();
        check("t4_release_same_cycle", 64'(busy1), 64'h0);
        for (int k = 0; k < 11; k++) begin
            tick();
            saw2 = saw2 | rxr1[2];
        end
        check("t4_ch2_never_accepted", 64'(saw2), 64'h0);
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        flush();
        en1 = 4'b1111;

        // Test 5: MAX_BURST=1, channels 0 and 3 alternate
        for (int k = 0; k < 6; k++) exp2_q.push_back((k % 2 == 0) ? 0 : 3);
        rxv2 = 4'b1001;
        repeat (12) @(posedge clk);
        #1;
        rxv2 = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        check("t5_drained", 64'(exp2_q.size()), 64'd0);

        // Test 6: asynchronous reset mid-burst on channel 1
        load(1, 600, 4);
        load(0, 700, 2);
        expect_item(1, 600);
        for (int i = 0; i < 2; i++) expect_item(0, 700 + i);
        expect_item(1, 602);
        expect_item(1, 603);
        drive();
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx_src_rdy", 64'(txv1), 64'h0);
        check("t6_rst_tx_data", txd1, 64'h0);
        check("t6_rst_tx_chan", 64'(txc1), 64'h0);
        check("t6_rst_busy", 64'(busy1), 64'h0);
        check("t6_rst_rx_dst_rdy", 64'(rxr1), 64'h0);
        rst_n = 1'b1;
        tick();
        check("t6_regrant_busy", 64'(busy1), 64'h1);
        check("t6_regrant_lowest", 64'(rxr1), 64'h1);
        n = 0;
        while (!src_empty() && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("t6_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
